// File: rtl/rd53_frame_scheduler.sv
// rd53_frame_scheduler
// Shares one 16-bit frame slot per serializer pull between external triggers,
// the command-word stream and sync/no-op fillers. Syncs are inserted at least
// every SYNC_INTERVAL non-sync frames, but never inside a multi-frame packet.
//
// Ports:
//   i_cmd_clk       command clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_enable        allow new packets to start
//   i_frame_rd      single-cycle pull strobe from the serializer
//   o_frame         frame to serialize (registered)
//   o_frame_type    0 sync, 1 trigger, 2 command, 3 no-op (registered)
//   i_trig_req      trigger pending, held until acknowledged
//   i_trig_pattern  bunch-crossing mask, 0 means no trigger
//   i_trig_tag      trigger tag, low byte of the trigger frame
//   o_trig_ack      combinational trigger-consumed strobe
//   i_cmd_valid     command word available
//   i_cmd_data      command word
//   i_cmd_last      last word of its packet
//   o_cmd_ready     combinational command-consumed strobe
//   o_in_packet     a packet is open (registered)
//   o_underrun_cnt  saturating count of no-ops emitted inside packets
module rd53_frame_scheduler #(
    parameter int unsigned SYNC_INTERVAL = 32
) (
    input  logic        i_cmd_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_frame_rd,
    output logic [15:0] o_frame,
    output logic [1:0]  o_frame_type,
    input  logic        i_trig_req,
    input  logic [3:0]  i_trig_pattern,
    input  logic [7:0]  i_trig_tag,
    output logic        o_trig_ack,
    input  logic        i_cmd_valid,
    input  logic [15:0] i_cmd_data,
    input  logic        i_cmd_last,
    output logic        o_cmd_ready,
    output logic        o_in_packet,
    output logic [7:0]  o_underrun_cnt
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned CNT_W   = 8;

    localparam logic [FRAME_W-1:0] SYNC_WORD  = 16'h817E;
    localparam logic [FRAME_W-1:0] NOOP_WORD  = 16'h6969;
    localparam logic [CNT_W-1:0]   CNT_MAX    = 8'hFF;
    localparam logic [CNT_W-1:0]   SYNC_LIMIT = CNT_W'(SYNC_INTERVAL);

    localparam logic [TYPE_W-1:0] FT_SYNC = 2'd0;
    localparam logic [TYPE_W-1:0] FT_TRIG = 2'd1;
    localparam logic [TYPE_W-1:0] FT_CMD  = 2'd2;
    localparam logic [TYPE_W-1:0] FT_NOOP = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [FRAME_W-1:0]   r_frame;
    logic [TYPE_W-1:0]    r_frame_type;
    logic [CNT_W-1:0]     r_since_sync;
    logic [CNT_W-1:0]     r_underrun_cnt;

    logic [FRAME_W-1:0]   w_frame_next;
    logic [TYPE_W-1:0]    w_type_next;
    logic                 w_trig_ack;
    logic                 w_cmd_ready;
    logic                 w_load_sync;
    logic                 w_load_other;
    logic                 w_load_noop;
    logic                 w_trig_valid;
    logic                 w_sync_due;
    logic [7:0]           w_trig_symbol;

    // A zero pattern carries no bunch crossing, so the request is ignored.
    assign w_trig_valid = i_trig_req && (i_trig_pattern != 4'd0);
    assign w_sync_due   = (r_since_sync >= SYNC_LIMIT);

    // Trigger pattern to 8-bit trigger symbol.
    always_comb begin
        w_trig_symbol = 8'h00;
        case (i_trig_pattern)
            4'd1:    w_trig_symbol = 8'h2B;
            4'd2:    w_trig_symbol = 8'h2D;
            4'd3:    w_trig_symbol = 8'h2E;
            4'd4:    w_trig_symbol = 8'h33;
            4'd5:    w_trig_symbol = 8'h35;
            4'd6:    w_trig_symbol = 8'h36;
            4'd7:    w_trig_symbol = 8'h39;
            4'd8:    w_trig_symbol = 8'h3A;
            4'd9:    w_trig_symbol = 8'h3C;
            4'd10:   w_trig_symbol = 8'h4B;
            4'd11:   w_trig_symbol = 8'h4D;
            4'd12:   w_trig_symbol = 8'h4E;
            4'd13:   w_trig_symbol = 8'h53;
            4'd14:   w_trig_symbol = 8'h55;
            4'd15:   w_trig_symbol = 8'h56;
            default: w_trig_symbol = 8'h00;
        endcase
    end

    // Packet state register.
    always_ff @(posedge i_cmd_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Per-pull arbitration: trigger, then sync (outside packets only),
    // then command word, then no-op filler inside an open packet.
    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame;
        w_type_next  = r_frame_type;
        w_trig_ack   = 1'b0;
        w_cmd_ready  = 1'b0;
        w_load_sync  = 1'b0;
        w_load_other = 1'b0;
        w_load_noop  = 1'b0;
        if (i_frame_rd) begin
            if (w_trig_valid) begin
                w_frame_next = {w_trig_symbol, i_trig_tag};
                w_type_next  = FT_TRIG;
                w_trig_ack   = 1'b1;
                w_load_other = 1'b1;
            end else if ((r_state == ST_IDLE) &&
                         (w_sync_due || !i_enable || !i_cmd_valid)) begin
                w_frame_next = SYNC_WORD;
                w_type_next  = FT_SYNC;
                w_load_sync  = 1'b1;
            end else if (i_cmd_valid) begin
                // Outside a packet, reaching here implies i_enable is set.
                w_frame_next = i_cmd_data;
                w_type_next  = FT_CMD;
                w_cmd_ready  = 1'b1;
                w_load_other = 1'b1;
                w_state_next = i_cmd_last ? ST_IDLE : ST_PACKET;
            end else begin
                // Only reachable with a packet open and no word available.
                w_frame_next = NOOP_WORD;
                w_type_next  = FT_NOOP;
                w_load_other = 1'b1;
                w_load_noop  = 1'b1;
            end
        end
    end

    // Frame output and counters.
    always_ff @(posedge i_cmd_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame        <= SYNC_WORD;
            r_frame_type   <= FT_SYNC;
            r_since_sync   <= '0;
            r_underrun_cnt <= '0;
        end else begin
            r_frame      <= w_frame_next;
            r_frame_type <= w_type_next;
            if (w_load_sync) begin
                r_since_sync <= '0;
            end else if (w_load_other && (r_since_sync != CNT_MAX)) begin
                r_since_sync <= r_since_sync + CNT_W'(1);
            end
            if (w_load_noop && (r_underrun_cnt != CNT_MAX)) begin
                r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
            end
        end
    end

    assign o_frame        = r_frame;
    assign o_frame_type   = r_frame_type;
    assign o_trig_ack     = w_trig_ack;
    assign o_cmd_ready    = w_cmd_ready;
    assign o_in_packet    = (r_state == ST_PACKET);
    assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_rd53_frame_scheduler.sv
// Testbench for rd53_frame_scheduler (SYNC_INTERVAL = 4): table of directed
// pulls with hand-computed frames, then sequences for underrun saturation,
// trigger-vs-overdue-sync, reset mid-packet and the full trigger symbol map.
module tb_rd53_frame_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        frame_rd;
    logic [15:0] frame;
    logic [1:0]  frame_type;
    logic        trig_req;
    logic [3:0]  trig_pattern;
    logic [7:0]  trig_tag;
    logic        trig_ack;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_last;
    logic        cmd_ready;
    logic        in_packet;
    logic [7:0]  underrun_cnt;

    int errors = 0;
    int checks = 0;

    logic cap_ack;
    logic cap_ready;

    typedef struct {
        logic        en;
        logic        req;
        logic [3:0]  pat;
        logic [7:0]  tag;
        logic        valid;
        logic [15:0] data;
        logic        last;
        logic [15:0] exp_frame;
        logic [1:0]  exp_type;
        logic        exp_ack;
        logic        exp_ready;
        logic        exp_inpkt;
        logic [7:0]  exp_und;
    } vec_t;

    vec_t tbl[32];
    logic [7:0] sym_tbl[16];

    rd53_frame_scheduler #(.SYNC_INTERVAL(4)) dut (
        .i_cmd_clk      (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_frame_rd     (frame_rd),
        .o_frame        (frame),
        .o_frame_type   (frame_type),
        .i_trig_req     (trig_req),
        .i_trig_pattern (trig_pattern),
        .i_trig_tag     (trig_tag),
        .o_trig_ack     (trig_ack),
        .i_cmd_valid    (cmd_valid),
        .i_cmd_data     (cmd_data),
        .i_cmd_last     (cmd_last),
        .o_cmd_ready    (cmd_ready),
        .o_in_packet    (in_packet),
        .o_underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic req, input logic [3:0] pat,
                                input logic [7:0] tag, input logic valid, input logic [15:0] data,
                                input logic last, input logic [15:0] ef, input logic [1:0] et,
                                input logic ea, input logic er, input logic ei, input logic [7:0] eu);
        vec_t v;
        v.en = en; v.req = req; v.pat = pat; v.tag = tag;
        v.valid = valid; v.data = data; v.last = last;
        v.exp_frame = ef; v.exp_type = et; v.exp_ack = ea;
        v.exp_ready = er; v.exp_inpkt = ei; v.exp_und = eu;
        return v;
    endfunction

    // One pull: strobe for one cycle, then one idle cycle before the next.
    task automatic pull(input logic en, input logic req, input logic [3:0] pat,
                        input logic [7:0] tag, input logic valid, input logic [15:0] data,
                        input logic last);
        @(negedge clk);
        enable = en; trig_req = req; trig_pattern = pat; trig_tag = tag;
        cmd_valid = valid; cmd_data = data; cmd_last = last;
        frame_rd = 1'b1;
        #1;
        cap_ack   = trig_ack;
        cap_ready = cmd_ready;
        @(posedge clk);
        #1;
        frame_rd = 1'b0;
        #1;
        check("idle_ack_ready", 16'({trig_ack, cmd_ready}), 16'd0);
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; frame_rd = 1'b0;
        trig_req = 1'b0; trig_pattern = 4'd0; trig_tag = 8'd0;
        cmd_valid = 1'b0; cmd_data = 16'd0; cmd_last = 1'b0;
        cap_ack = 1'b0; cap_ready = 1'b0;

        sym_tbl[0]  = 8'h00; sym_tbl[1]  = 8'h2B; sym_tbl[2]  = 8'h2D; sym_tbl[3]  = 8'h2E;
        sym_tbl[4]  = 8'h33; sym_tbl[5]  = 8'h35; sym_tbl[6]  = 8'h36; sym_tbl[7]  = 8'h39;
        sym_tbl[8]  = 8'h3A; sym_tbl[9]  = 8'h3C; sym_tbl[10] = 8'h4B; sym_tbl[11] = 8'h4D;
        sym_tbl[12] = 8'h4E; sym_tbl[13] = 8'h53; sym_tbl[14] = 8'h55; sym_tbl[15] = 8'h56;

        // ENABLE low: syncs only, command offered but never taken.
        tbl[0]  = mk(0,0,0,8'h00,0,16'h0000,0, 16'h817E,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,8'h00,0,16'h0000,0, 16'h817E,0,0,0,0,0);
        tbl[2]  = mk(0,0,0,8'h00,1,16'hAAAA,0, 16'h817E,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,8'h00,1,16'hAAAA,0, 16'h817E,0,0,0,0,0);
        tbl[4]  = mk(0,0,0,8'h00,1,16'hAAAA,1, 16'h817E,0,0,0,0,0);
        // 3-word packet with a trigger interleaved before word 2.
        tbl[5]  = mk(1,0,0,8'h00,1,16'h1111,0, 16'h1111,2,0,1,1,0);
        tbl[6]  = mk(1,1,5,8'h6A,1,16'h2222,0, 16'h356A,1,1,0,1,0);
        tbl[7]  = mk(1,0,0,8'h00,1,16'h2222,0, 16'h2222,2,0,1,1,0);
        tbl[8]  = mk(1,0,0,8'h00,1,16'h3333,1, 16'h3333,2,0,1,0,0);
        tbl[9]  = mk(1,0,0,8'h00,1,16'h4444,1, 16'h817E,0,0,0,0,0);
        // Single-word packets: sync on every 5th frame.
        tbl[10] = mk(1,0,0,8'h00,1,16'h5001,1, 16'h5001,2,0,1,0,0);
        tbl[11] = mk(1,0,0,8'h00,1,16'h5002,1, 16'h5002,2,0,1,0,0);
        tbl[12] = mk(1,0,0,8'h00,1,16'h5003,1, 16'h5003,2,0,1,0,0);
        tbl[13] = mk(1,0,0,8'h00,1,16'h5004,1, 16'h5004,2,0,1,0,0);
        tbl[14] = mk(1,0,0,8'h00,1,16'h5005,1, 16'h817E,0,0,0,0,0);
        // 6-word packet spanning the deadline; sync right after LAST.
        tbl[15] = mk(1,0,0,8'h00,1,16'h6001,0, 16'h6001,2,0,1,1,0);
        tbl[16] = mk(1,0,0,8'h00,1,16'h6002,0, 16'h6002,2,0,1,1,0);
        tbl[17] = mk(1,0,0,8'h00,1,16'h6003,0, 16'h6003,2,0,1,1,0);
        tbl[18] = mk(1,0,0,8'h00,1,16'h6004,0, 16'h6004,2,0,1,1,0);
        tbl[19] = mk(1,0,0,8'h00,1,16'h6005,0, 16'h6005,2,0,1,1,0);
        tbl[20] = mk(1,0,0,8'h00,1,16'h6006,1, 16'h6006,2,0,1,0,0);
        tbl[21] = mk(1,0,0,8'h00,1,16'h7001,0, 16'h817E,0,0,0,0,0);
        // Underrun inside a packet, then zero-pattern trigger ignored.
        tbl[22] = mk(1,0,0,8'h00,1,16'h7001,0, 16'h7001,2,0,1,1,0);
        tbl[23] = mk(1,0,0,8'h00,0,16'h0000,0, 16'h6969,3,0,0,1,1);
        tbl[24] = mk(1,0,0,8'h00,0,16'h0000,0, 16'h6969,3,0,0,1,2);
        tbl[25] = mk(1,0,0,8'h00,0,16'h0000,0, 16'h6969,3,0,0,1,3);
        tbl[26] = mk(1,1,0,8'h77,1,16'h7002,1, 16'h7002,2,0,1,0,3);
        tbl[27] = mk(1,1,0,8'h77,0,16'h0000,0, 16'h817E,0,0,0,0,3);
        // ENABLE falls mid-packet: packet completes, then sync.
        tbl[28] = mk(1,0,0,8'h00,1,16'h8001,0, 16'h8001,2,0,1,1,3);
        tbl[29] = mk(0,0,0,8'h00,1,16'h8002,0, 16'h8002,2,0,1,1,3);
        tbl[30] = mk(0,0,0,8'h00,1,16'h8003,1, 16'h8003,2,0,1,0,3);
        tbl[31] = mk(0,0,0,8'h00,1,16'h8004,0, 16'h817E,0,0,0,0,3);

        repeat (3) @(posedge clk);
        #1;
        check("rst_frame", frame, 16'h817E);
        check("rst_type", 16'(frame_type), 16'd0);
        check("rst_in_packet", 16'(in_packet), 16'd0);
        check("rst_underrun", 16'(underrun_cnt), 16'd0);
        check("rst_ack_ready", 16'({trig_ack, cmd_ready}), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            pull(tbl[i].en, tbl[i].req, tbl[i].pat, tbl[i].tag,
                 tbl[i].valid, tbl[i].data, tbl[i].last);
            check($sformatf("v%0d_frame", i), frame, tbl[i].exp_frame);
            check($sformatf("v%0d_type", i), 16'(frame_type), 16'(tbl[i].exp_type));
            check($sformatf("v%0d_ack", i), 16'(cap_ack), 16'(tbl[i].exp_ack));
            check($sformatf("v%0d_ready", i), 16'(cap_ready), 16'(tbl[i].exp_ready));
            check($sformatf("v%0d_in_packet", i), 16'(in_packet), 16'(tbl[i].exp_inpkt));
            check($sformatf("v%0d_underrun", i), 16'(underrun_cnt), 16'(tbl[i].exp_und));
        end

        // Long underrun: counter saturates at 255.
        pull(1, 0, 4'd0, 8'h00, 1, 16'h9001, 0);
        check("sat_open", 16'(in_packet), 16'd1);
        for (int i = 0; i < 300; i++) begin
            pull(1, 0, 4'd0, 8'h00, 0, 16'h0000, 0);
        end
        check("sat_frame", frame, 16'h6969);
        check("sat_type", 16'(frame_type), 16'd3);
        check("sat_underrun", 16'(underrun_cnt), 16'd255);
        pull(1, 0, 4'd0, 8'h00, 1, 16'h9002, 1);
        check("sat_last_frame", frame, 16'h9002);
        check("sat_closed", 16'(in_packet), 16'd0);
        // Overdue sync yields to a pending trigger, then follows it.
        pull(1, 1, 4'd15, 8'h01, 1, 16'h9003, 0);
        check("overdue_trig_frame", frame, 16'h5601);
        check("overdue_trig_ack", 16'(cap_ack), 16'd1);
        check("overdue_trig_ready", 16'(cap_ready), 16'd0);
        pull(1, 0, 4'd0, 8'h00, 1, 16'h9003, 0);
        check("overdue_sync_frame", frame, 16'h817E);
        check("overdue_sync_ready", 16'(cap_ready), 16'd0);

        // Reset mid-packet clears state immediately.
        pull(1, 0, 4'd0, 8'h00, 1, 16'hA001, 0);
        check("rstmid_open", 16'(in_packet), 16'd1);
        check("rstmid_open_frame", frame, 16'hA001);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_in_packet", 16'(in_packet), 16'd0);
        check("rstmid_frame", frame, 16'h817E);
        check("rstmid_type", 16'(frame_type), 16'd0);
        check("rstmid_underrun", 16'(underrun_cnt), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        pull(1, 0, 4'd0, 8'h00, 0, 16'h0000, 0);
        check("rstmid_next_frame", frame, 16'h817E);
        check("rstmid_next_type", 16'(frame_type), 16'd0);

        // Every trigger pattern maps to its symbol.
        for (int p = 1; p < 16; p++) begin
            pull(0, 1, 4'(p), 8'(p * 16 + 1), 0, 16'h0000, 0);
            check($sformatf("trig%0d_frame", p), frame, {sym_tbl[p], 8'(p * 16 + 1)});
            check($sformatf("trig%0d_type", p), 16'(frame_type), 16'd1);
            check($sformatf("trig%0d_ack", p), 16'(cap_ack), 16'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
